key_filter: RTL and testbench

Debounces one raw mechanical push-button and produces the clean one-cycle press/release events that drive the `Beep` block's `En` input and other key consumers in the key subsystem. The raw input is synchronized and edge-detected. A four-state machine then confirms each level change only after it has been stable for a programmable window. Confirmed presses emit `key_press`, confirmed releases emit `key_release`, and `key_state` tracks the debounced level.

---
 rtl/key_filter_pkg.sv | 20 ++
 rtl/key_filter_sync.sv | 35 +++
 rtl/key_filter.sv | 113 +++++++++++
 tb/tb_key_filter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/key_filter_pkg.sv
// Shared key-subsystem definitions: debounce state encoding and default timing.
// Also intended for the multi-key scanner.
package key_filter_pkg;

  typedef enum logic [1:0] {
    KS_IDLE    = 2'd0,
    KS_FILT_DN = 2'd1,
    KS_DOWN    = 2'd2,
    KS_FILT_UP = 2'd3
  } key_fsm_e;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 32'd1_000_000;
  localparam int unsigned DEFAULT_CNT_W           = 32'd24;

  // Debounced level seen by consumers: pressed while held or while a release is unconfirmed.
  function automatic logic is_pressed(input key_fsm_e s);
    return (s == KS_DOWN) || (s == KS_FILT_UP);
  endfunction

endpackage

// File: rtl/key_filter_sync.sv
// Two-flop synchronizer plus history flop for one raw key line.
// Exposes the synchronized level and its falling/rising edge strobes.
module key_filter_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key,
  output logic o_level,
  output logic o_nedge,
  output logic o_pedge
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  // Synchronizer and history chain
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1 <= RST_VAL;
      r_s2 <= RST_VAL;
      r_s3 <= RST_VAL;
    end else begin
      r_s1 <= i_key;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_level = r_s2;
  assign o_nedge = r_s3 & ~r_s2;
  assign o_pedge = ~r_s3 & r_s2;

endmodule

// File: rtl/key_filter.sv
// Push-button debouncer: four-state confirm FSM with a stable-time counter,
// producing registered one-cycle press/release pulses and the debounced level.
module key_filter
  import key_filter_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = DEFAULT_CNT_W
) (
  input  logic Clk,
  input  logic Rst,
  input  logic key_in,
  output logic key_press,
  output logic key_release,
  output logic key_state
);

  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

  key_fsm_e         r_state;
  key_fsm_e         w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_press_next;
  logic             w_release_next;
  logic             w_level;
  logic             w_nedge;
  logic             w_pedge;
  logic [1:0]       r_fill;
  logic             r_armed;
  logic             w_nedge_armed;

  key_filter_sync #(.RST_VAL(1'b1)) u_sync (
    .i_clk   (Clk),
    .i_rst   (Rst),
    .i_key   (key_in),
    .o_level (w_level),
    .o_nedge (w_nedge),
    .o_pedge (w_pedge)
  );

  // A press is only accepted once the synchronized line has been seen released
  // after reset, so a key held through reset is not reported.
  assign w_nedge_armed = w_nedge & r_armed;

  // Next-state, counter and pulse decode; edges outrank the terminal count
  always_comb begin
    w_next         = r_state;
    w_cnt_next     = {CNT_W{1'b0}};
    w_press_next   = 1'b0;
    w_release_next = 1'b0;
    case (r_state)
      KS_IDLE: begin
        if (w_nedge_armed) begin
          w_next = KS_FILT_DN;
        end else begin
          w_next = KS_IDLE;
        end
      end
      KS_FILT_DN: begin
        if (w_pedge) begin
          w_next = KS_IDLE;
        end else if (r_cnt == TERM_CNT) begin
          w_next       = KS_DOWN;
          w_press_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      KS_DOWN: begin
        if (w_pedge) begin
          w_next = KS_FILT_UP;
        end else begin
          w_next = KS_DOWN;
        end
      end
      KS_FILT_UP: begin
        if (w_nedge) begin
          w_next = KS_DOWN;
        end else if (r_cnt == TERM_CNT) begin
          w_next         = KS_IDLE;
          w_release_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_next = KS_IDLE;
      end
    endcase
  end

  // State, counter, arming and registered outputs
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state     <= KS_IDLE;
      r_cnt       <= {CNT_W{1'b0}};
      r_fill      <= 2'b00;
      r_armed     <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_state   <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cnt       <= w_cnt_next;
      r_fill      <= {r_fill[0], 1'b1};
      r_armed     <= r_armed | (r_fill[1] & w_level);
      key_press   <= w_press_next;
      key_release <= w_release_next;
      key_state   <= is_pressed(w_next);
    end
  end

endmodule

// File: tb/tb_key_filter.sv
// Bench for key_filter: directed scenarios plus random key waveforms, checked
// every cycle against a run-length model of the debounce rules.
module tb_key_filter;

  localparam int D = 100;

  logic Clk;
  logic Rst;
  logic key_in;
  logic key_press;
  logic key_release;
  logic key_state;

  int n_vec = 0;
  int n_err = 0;
  int n_press_seen = 0;

  key_filter #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .key_in      (key_in),
    .key_press   (key_press),
    .key_release (key_release),
    .key_state   (key_state)
  );

  initial begin
    Clk = 1'b0;
    forever #10 Clk = ~Clk;
  end

  // Model: the synchronized level is key_in from two edges back (released before
  // that). A press is confirmed when a run of D+1 low levels completes while
  // released and armed; a release when D+1 high levels complete while pressed.
  bit q[$];
  int zrun, orun;
  bit m_pressed, m_armed, exp_press, exp_rel;

  always @(posedge Clk or posedge Rst) begin
    bit lvl;
    bit armed_b;
    if (Rst) begin
      q.delete();
      zrun = 0; orun = 0;
      m_pressed = 1'b0; m_armed = 1'b0;
      exp_press = 1'b0; exp_rel = 1'b0;
    end else begin
      q.push_back(key_in);
      if (q.size() > 3) void'(q.pop_front());
      lvl = (q.size() == 3) ? q[0] : 1'b1;
      armed_b = m_armed;
      if (lvl) begin orun++; zrun = 0; end
      else begin zrun++; orun = 0; end
      exp_press = !m_pressed && armed_b && (zrun == D + 1);
      exp_rel   = m_pressed && (orun == D + 1);
      if (exp_press) m_pressed = 1'b1;
      if (exp_rel) m_pressed = 1'b0;
      if (q.size() == 3 && lvl) m_armed = 1'b1;
    end
  end

  always @(negedge Clk) begin
    n_vec++;
    if (key_press !== exp_press) begin
      n_err++; $display("FAIL key_press: got %b want %b at %0t", key_press, exp_press, $time);
    end
    if (key_release !== exp_rel) begin
      n_err++; $display("FAIL key_release: got %b want %b at %0t", key_release, exp_rel, $time);
    end
    if (key_state !== m_pressed) begin
      n_err++; $display("FAIL key_state: got %b want %b at %0t", key_state, m_pressed, $time);
    end
    if (key_press === 1'b1 && key_release === 1'b1) begin
      n_err++; $display("FAIL pulse_overlap: got both high want exclusive at %0t", $time);
    end
    if (key_press === 1'b1) n_press_seen++;
  end

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic hold(input bit v, input int n);
    key_in = v;
    repeat (n) begin @(posedge Clk); #5; end
  endtask

  // Edges from the input change until the chosen pulse is seen; 300 means timeout.
  task automatic measure(input bit want_rel, output int n);
    n = 0;
    while (n < 300) begin
      @(posedge Clk); #1; n++;
      if (want_rel ? key_release : key_press) break;
    end
  endtask

  int lat, base;

  initial begin
    Rst = 1'b1;
    key_in = 1'b0;
    repeat (10) begin @(posedge Clk); #5; end
    check("rst_press", key_press, 0);
    check("rst_release", key_release, 0);
    check("rst_state", key_state, 0);
    Rst = 1'b0;

    base = n_press_seen;
    hold(0, 300);
    check("held_through_reset_no_press", n_press_seen - base, 0);
    hold(1, 200);

    key_in = 1'b0;
    measure(1'b0, lat);
    check("press_latency", lat, 103);
    check("state_after_press", key_state, 1);
    hold(0, 400);
    key_in = 1'b1;
    measure(1'b1, lat);
    check("release_latency", lat, 103);
    check("state_after_release", key_state, 0);
    hold(1, 200);

    base = n_press_seen;
    for (int i = 0; i < 5; i++) begin
      hold(0, $urandom_range(10, 40));
      hold(1, $urandom_range(10, 40));
    end
    check("bounce_no_press", n_press_seen - base, 0);
    key_in = 1'b0;
    measure(1'b0, lat);
    check("bounce_press_latency", lat, 103);
    hold(0, 200);
    hold(1, 300);

    base = n_press_seen;
    hold(0, D);
    hold(1, 300);
    check("terminal_collision_no_press", n_press_seen - base, 0);
    check("terminal_collision_state", key_state, 0);
    base = n_press_seen;
    hold(0, D + 1);
    hold(1, 300);
    check("min_stable_press", n_press_seen - base, 1);

    hold(0, 53);
    Rst = 1'b1;
    #1;
    check("midrst_press", key_press, 0);
    check("midrst_state", key_state, 0);
    repeat (2) begin @(posedge Clk); #5; end
    Rst = 1'b0;
    base = n_press_seen;
    hold(0, 300);
    check("midrst_no_press", n_press_seen - base, 0);
    hold(1, 200);
    key_in = 1'b0;
    measure(1'b0, lat);
    check("fresh_press_latency", lat, 103);
    hold(0, 300);
    check("held_single_press", n_press_seen - base, 1);
    hold(1, 300);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0: hold(i[0], $urandom_range(1, 30));
        1: hold(i[0], $urandom_range(D - 1, D + 2));
        default: hold(i[0], $urandom_range(120, 260));
      endcase
    end
    hold(1, 300);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
